// File: rtl/uart_frame_loader_pkg.sv
// Shared types and defaults for the UART frame loader: parser states and frame constants.
package uart_frame_loader_pkg;

    typedef enum logic [2:0] {
        StHunt,
        StSync,
        StLenHi,
        StLenLo,
        StPayload,
        StCksum
    } loader_state_e;

    localparam logic [7:0]  SYNC0_DEFAULT     = 8'hAA;
    localparam logic [7:0]  SYNC1_DEFAULT     = 8'h55;
    localparam int unsigned MAX_BYTES_DEFAULT = 16384;

endpackage

// File: rtl/uart_frame_loader_byte_timeout.sv
// Inter-byte idle watchdog: counts cycles without a kick while enabled and pulses on expiry.
module byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    // A kick on the expiry cycle wins: the byte is processed and no expiry is reported.
    assign expired = enable && !kick && (cnt_q == Limit);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable || kick || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses sync/length/payload/checksum frames from the UART receiver and streams payload
// bytes into the sample BRAM; load_done fires only for a checksum-verified frame.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned MAX_BYTES      = MAX_BYTES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC0          = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1          = SYNC1_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              recv_done,
    input  logic [7:0]        recv_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              load_busy,
    output logic              load_done,
    output logic [15:0]       frame_len,
    output logic              err_checksum,
    output logic              err_timeout,
    output logic              err_overflow
);

    loader_state_e state_q, state_d;

    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   idx_inc;
    logic [7:0]        sum_q, sum_d;
    logic [15:0]       frame_len_q, frame_len_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              done_q, done_d;
    logic              cks_err_q, cks_err_d;
    logic              to_err_q, to_err_d;
    logic              ov_err_q, ov_err_d;
    logic              expired;

    byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_timeout (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable    (state_q != StHunt),
        .kick      (recv_done),
        .expired   (expired)
    );

    // Index is one bit wider than the address so a MAX_BYTES-long payload ends without wrap.
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        frame_len_d = frame_len_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        done_d      = 1'b0;
        cks_err_d   = 1'b0;
        to_err_d    = 1'b0;
        ov_err_d    = 1'b0;

        if (expired) begin
            to_err_d = 1'b1;
            state_d  = StHunt;
        end else if (recv_done) begin
            unique case (state_q)
                StHunt: begin
                    if (recv_data == SYNC0) state_d = StSync;
                end
                StSync: begin
                    if (recv_data == SYNC1) begin
                        state_d = StLenHi;
                    end else if (recv_data != SYNC0) begin
                        state_d = StHunt;
                    end
                end
                StLenHi: begin
                    len_d   = {recv_data, 8'h00};
                    state_d = StLenLo;
                end
                StLenLo: begin
                    len_d = {len_q[15:8], recv_data};
                    idx_d = '0;
                    sum_d = '0;
                    if (32'(len_d) > MAX_BYTES) begin
                        ov_err_d = 1'b1;
                        state_d  = StHunt;
                    end else if (len_d == 16'd0) begin
                        state_d = StCksum;
                    end else begin
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = idx_q[ADDR_W-1:0];
                    ram_wdata_d = recv_data;
                    sum_d       = sum_q + recv_data;
                    idx_d       = idx_inc;
                    if (32'(idx_inc) == 32'(len_q)) state_d = StCksum;
                end
                StCksum: begin
                    state_d = StHunt;
                    if (recv_data == sum_q) begin
                        done_d      = 1'b1;
                        frame_len_d = len_q;
                    end else begin
                        cks_err_d = 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StHunt;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            frame_len_q <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            done_q      <= 1'b0;
            cks_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
            ov_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            frame_len_q <= frame_len_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            done_q      <= done_d;
            cks_err_q   <= cks_err_d;
            to_err_q    <= to_err_d;
            ov_err_q    <= ov_err_d;
        end
    end

    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign load_busy    = (state_q != StHunt);
    assign load_done    = done_q;
    assign frame_len    = frame_len_q;
    assign err_checksum = cks_err_q;
    assign err_timeout  = to_err_q;
    assign err_overflow = ov_err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: good/bad frames, timeout, overflow, resync,
// reset mid-frame and a byte colliding with the timeout expiry cycle.
module tb_uart_frame_loader;

    localparam int unsigned T      = 40;
    localparam int unsigned ADDR_W = 14;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              recv_done = 1'b0;
    logic [7:0]        recv_data = 8'h00;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              load_busy;
    logic              load_done;
    logic [15:0]       frame_len;
    logic              err_checksum;
    logic              err_timeout;
    logic              err_overflow;

    uart_frame_loader #(
        .ADDR_W         (ADDR_W),
        .MAX_BYTES      (16384),
        .TIMEOUT_CYCLES (T),
        .SYNC0          (8'hAA),
        .SYNC1          (8'h55)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .recv_done    (recv_done),
        .recv_data    (recv_data),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .frame_len    (frame_len),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse/write tallies sampled mid-cycle; tests compare deltas against snapshots.
    int we_cnt = 0, done_cnt = 0, cks_cnt = 0, to_cnt = 0, ov_cnt = 0, excl_cnt = 0;
    always @(negedge sys_clk) begin
        if (ram_we)       we_cnt   <= we_cnt + 1;
        if (load_done)    done_cnt <= done_cnt + 1;
        if (err_checksum) cks_cnt  <= cks_cnt + 1;
        if (err_timeout)  to_cnt   <= to_cnt + 1;
        if (err_overflow) ov_cnt   <= ov_cnt + 1;
        if (int'(load_done) + int'(err_checksum) + int'(err_timeout) + int'(err_overflow) > 1)
            excl_cnt <= excl_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;
    int unsigned last_rx = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that samples the byte.
    task automatic send_byte(input logic [7:0] b);
        recv_data = b;
        recv_done = 1'b1;
        last_rx   = cyc;
        @(posedge sys_clk);
        #1;
        recv_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    int we0, done0, cks0, to0, ov0;
    task automatic snap();
        idle(1);
        we0 = we_cnt; done0 = done_cnt; cks0 = cks_cnt; to0 = to_cnt; ov0 = ov_cnt;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_wr"}, {ram_we, ram_addr, ram_wdata}, 64'd0);
        check_eq({tag, "_st"}, {load_busy, load_done, err_checksum, err_timeout, err_overflow},
                 64'd0);
        check_eq({tag, "_len"}, frame_len, 64'd0);
    endtask

    initial begin
        bit          seen;
        int unsigned t0;
        int unsigned tp;
        logic [7:0]  pay[4];
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outs("reset");
        sys_rst_n = 1'b1;
        snap();

        // Good frame, with per-byte write timing.
        send_byte(8'hAA);
        check_eq("busy_after_sync0", load_busy, 64'd1);
        send_seq('{8'h55, 8'h00, 8'h04});
        for (int i = 0; i < 4; i++) begin
            send_byte(pay[i]);
            check_eq("good_we", ram_we, 64'd1);
            check_eq("good_addr", ram_addr, 64'(i));
            check_eq("good_wdata", ram_wdata, 64'(pay[i]));
        end
        send_byte(8'hAA);
        check_eq("good_done", {load_done, load_busy, err_checksum}, 64'b100);
        check_eq("good_len", frame_len, 64'd4);
        idle(1);
        check_eq("good_done_1cyc", load_done, 64'd0);
        check_eq("good_writes", we_cnt - we0, 64'd4);
        snap();

        // Bad checksum: sum is 03, sent 04.
        send_seq('{8'hAA, 8'h55, 8'h00, 8'h02, 8'h01, 8'h02, 8'h04});
        check_eq("bad_cks_pulse", {err_checksum, load_done, load_busy}, 64'b100);
        check_eq("bad_cks_len", frame_len, 64'd4);
        idle(1);
        check_eq("bad_cks_writes", we_cnt - we0, 64'd2);
        check_eq("bad_cks_nodone", done_cnt - done0, 64'd0);
        snap();

        // Timeout after 3 of 8 payload bytes; pulse lands T+2 cycles after the last byte cycle.
        send_seq('{8'hAA, 8'h55, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33});
        t0   = last_rx;
        seen = 1'b0;
        tp   = 0;
        for (int i = 0; i < 4 * int'(T); i++) begin
            @(posedge sys_clk);
            #1;
            if (err_timeout) begin
                seen = 1'b1;
                tp   = cyc;
                break;
            end
        end
        check_eq("timeout_seen", seen, 64'd1);
        check_eq("timeout_latency", tp - t0, 64'(T + 2));
        check_eq("timeout_busy", load_busy, 64'd0);
        send_seq('{8'hAA, 8'h55, 8'h00, 8'h01, 8'h5A, 8'h5A});
        check_eq("after_to_done", load_done, 64'd1);
        check_eq("after_to_len", frame_len, 64'd1);
        idle(1);
        check_eq("timeout_count", to_cnt - to0, 64'd1);
        snap();

        // Overflow: 0x4001 > 16384.
        send_seq('{8'hAA, 8'h55, 8'h40, 8'h01});
        check_eq("ovf_pulse", {err_overflow, load_busy}, 64'b10);
        idle(1);
        check_eq("ovf_writes", we_cnt - we0, 64'd0);
        check_eq("ovf_count", ov_cnt - ov0, 64'd1);
        snap();

        // Zero length with junk byte and a repeated sync0.
        send_byte(8'h37);
        check_eq("junk_not_busy", load_busy, 64'd0);
        send_seq('{8'hAA, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00});
        check_eq("zero_done", load_done, 64'd1);
        check_eq("zero_len", frame_len, 64'd0);
        idle(1);
        check_eq("zero_writes", we_cnt - we0, 64'd0);
        snap();

        // Reset mid-payload.
        send_seq('{8'hAA, 8'h55, 8'h00, 8'h04, 8'h11, 8'h22});
        sys_rst_n = 1'b0;
        #2;
        check_reset_outs("midreset");
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        idle(2);
        check_reset_outs("postreset");
        send_seq('{8'hAA, 8'h55, 8'h00, 8'h02, 8'h10});
        check_eq("rst_first_addr", {ram_we, ram_addr}, {1'b1, 14'd0});
        send_seq('{8'h20, 8'h30});
        check_eq("rst_frame_done", load_done, 64'd1);
        check_eq("rst_frame_len", frame_len, 64'd2);
        snap();

        // Byte lands exactly on the expiry cycle: accepted, no timeout.
        send_seq('{8'hAA, 8'h55, 8'h00, 8'h02});
        idle(int'(T));
        send_byte(8'h07);
        check_eq("collide_we", {ram_we, ram_wdata}, {1'b1, 8'h07});
        check_eq("collide_no_to", err_timeout, 64'd0);
        idle(int'(T));
        send_byte(8'h08);
        send_byte(8'h0F);
        check_eq("collide_done", load_done, 64'd1);
        idle(1);
        check_eq("collide_to_count", to_cnt - to0, 64'd0);

        check_eq("pulse_exclusive", excl_cnt, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
